// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: undelayed coordinates/strobes for the pixel source,
// pipeline-aligned sync/de for the HDMI transmitter, and the frame counter.
interface video_timing_gen_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] frame_cnt;

  modport master (
    output x, y, active, line_start, frame_start, hsync, vsync, de, frame_cnt
  );

  modport slave (
    input  x, y, active, line_start, frame_start, hsync, vsync, de, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator; x/y/active/strobes are undelayed.
// hsync/vsync/de lag them by PIPE_LAT cycles to meet rgb; no backpressure.
module video_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_LAT    = 2
) (
  input  logic               clk_pixel,
  input  logic               rst,
  video_timing_gen_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1 ||
      PIPE_LAT > 15 || PIPE_LAT < 0) begin : g_param_err
    $error("video_timing_gen: totals must be 1..1024 and PIPE_LAT 0..15");
  end

  // Decode is done on 11-bit values so a 1024-wide active region still compares correctly.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  IDLE   = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [15:0] frame_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_last;
  logic        v_last;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end
      if (h_last && v_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Raw decode is forced idle under reset so the zero-latency build also shows idle levels.
  logic       active_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] raw_bus;
  logic [2:0] dly;

  always_comb begin
    active_raw = !rst && (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_raw     = ~SYNC_ACTIVE;
    vs_raw     = ~SYNC_ACTIVE;
    if (!rst && (h_ext >= HS_BEG) && (h_ext < HS_END)) begin
      hs_raw = SYNC_ACTIVE;
    end
    if (!rst && (v_ext >= VS_BEG) && (v_ext < VS_END)) begin
      vs_raw = SYNC_ACTIVE;
    end
  end

  assign raw_bus = {hs_raw, vs_raw, active_raw};

  if (PIPE_LAT == 0) begin : g_no_pipe
    assign dly = raw_bus;
  end else begin : g_pipe
    logic [2:0] stage [PIPE_LAT];

    // Reset flushes every stage to idle so no partial sync/de pulse escapes.
    always_ff @(posedge clk_pixel) begin
      if (rst) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
          stage[i] <= IDLE;
        end
      end else begin
        stage[0] <= raw_bus;
        for (int i = 1; i < PIPE_LAT; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dly = stage[PIPE_LAT-1];
  end

  assign vt.x           = h_cnt;
  assign vt.y           = v_cnt;
  assign vt.active      = active_raw;
  assign vt.line_start  = !rst && (h_cnt == 10'd0);
  assign vt.frame_start = !rst && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign vt.hsync       = dly[2];
  assign vt.vsync       = dly[1];
  assign vt.de          = dly[0];
  assign vt.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Four generator configurations run side by side under random resets; a
// position-since-reset model predicts every output and a monitor scores them.
module tb_video_timing_gen;

  localparam int NI   = 4;
  localparam int NCYC = 66000;

  // 0: real 640x480 timing, 1/2: small raster with/without delay, 3: 1x1 raster for wrap.
  localparam int HA [NI] = '{640, 16, 16, 1};
  localparam int HF [NI] = '{16,  2,  2,  0};
  localparam int HS [NI] = '{96,  4,  4,  0};
  localparam int HB [NI] = '{48,  3,  3,  0};
  localparam int VA [NI] = '{480, 6,  6,  1};
  localparam int VF [NI] = '{10,  1,  1,  0};
  localparam int VS [NI] = '{2,   2,  2,  0};
  localparam int VB [NI] = '{33,  2,  2,  0};
  localparam bit SA [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int PL [NI] = '{2,   3,  0,  1};
  // Targeted one-cycle reset position (x, y, minimum frame index).
  localparam int TX [NI] = '{700, 20, 20, 0};
  localparam int TY [NI] = '{1,   3,  3,  0};
  localparam int TF [NI] = '{0,   2,  2,  0};

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] frame_cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst_v = '1;
  obs_t          act [NI];
  obs_t          exp_q [NI][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    video_timing_gen_if vif ();
    video_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .SYNC_ACTIVE(SA[g]), .PIPE_LAT(PL[g])
    ) u_dut (
      .clk_pixel(clk),
      .rst      (rst_v[g]),
      .vt       (vif)
    );
    assign act[g] = {vif.x, vif.y, vif.active, vif.line_start, vif.frame_start,
                     vif.hsync, vif.vsync, vif.de, vif.frame_cnt};
  end

  // Expected outputs purely from cycles elapsed since the last reset edge.
  function automatic obs_t model(int i, longint pos, bit r);
    obs_t o;
    int   ht, vt, x, y, qx, qy;
    ht = HA[i] + HF[i] + HS[i] + HB[i];
    vt = VA[i] + VF[i] + VS[i] + VB[i];
    x  = int'(pos % ht);
    y  = int'((pos / ht) % vt);
    o.x           = 10'(x);
    o.y           = 10'(y);
    o.frame_cnt   = 16'((pos / (ht * vt)) % 65536);
    o.active      = !r && x < HA[i] && y < VA[i];
    o.line_start  = !r && x == 0;
    o.frame_start = !r && x == 0 && y == 0;
    if ((PL[i] == 0 && r) || pos < PL[i]) begin
      o.hsync = !SA[i];
      o.vsync = !SA[i];
      o.de    = 1'b0;
    end else begin
      qx = int'((pos - PL[i]) % ht);
      qy = int'(((pos - PL[i]) / ht) % vt);
      o.hsync = (qx >= HA[i] + HF[i] && qx < HA[i] + HF[i] + HS[i]) ? SA[i] : !SA[i];
      o.vsync = (qy >= VA[i] + VF[i] && qy < VA[i] + VF[i] + VS[i]) ? SA[i] : !SA[i];
      o.de    = qx < HA[i] && qy < VA[i];
    end
    return o;
  endfunction

  task automatic chk(input string name, input int i, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, i, $time, a, e);
    end
  endtask

  logic [15:0] prev_fc3 = 16'h0;
  bit          seen_wrap = 1'b0;

  // Monitor: one expected entry per instance per cycle, compared mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          chk("x",           i, 16'(act[i].x),           16'(e.x));
          chk("y",           i, 16'(act[i].y),           16'(e.y));
          chk("active",      i, 16'(act[i].active),      16'(e.active));
          chk("line_start",  i, 16'(act[i].line_start),  16'(e.line_start));
          chk("frame_start", i, 16'(act[i].frame_start), 16'(e.frame_start));
          chk("hsync",       i, 16'(act[i].hsync),       16'(e.hsync));
          chk("vsync",       i, 16'(act[i].vsync),       16'(e.vsync));
          chk("de",          i, 16'(act[i].de),          16'(e.de));
          chk("frame_cnt",   i, act[i].frame_cnt,        e.frame_cnt);
          if (i == 3) begin
            if (prev_fc3 == 16'hFFFF && act[i].frame_cnt == 16'h0000) seen_wrap = 1'b1;
            prev_fc3 = act[i].frame_cnt;
          end
        end
      end
    end
  end

  // Stimulus: 5-cycle power-on reset, one targeted mid-frame reset per instance,
  // then sparse random resets of 1..3 cycles (never on the wrap instance).
  initial begin
    longint pos [NI];
    int     rem [NI];
    bit     tgt_done [NI];
    bit     r;
    obs_t   m;
    for (int i = 0; i < NI; i++) begin
      pos[i]      = 0;
      rem[i]      = 4;
      tgt_done[i] = (i == 3);
    end
    rst_v = '1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (rst_v[i]) pos[i] = 0;
        else          pos[i] = pos[i] + 1;
        m = model(i, pos[i], 1'b0);
        r = 1'b0;
        if (rem[i] > 0) begin
          r = 1'b1;
          rem[i]--;
        end else if (!tgt_done[i] && int'(m.x) == TX[i] && int'(m.y) == TY[i] &&
                     int'(m.frame_cnt) >= TF[i]) begin
          r = 1'b1;
          tgt_done[i] = 1'b1;
        end else if (i != 3 && $urandom_range(1999) == 0) begin
          r = 1'b1;
          rem[i] = int'($urandom_range(2));
        end
        rst_v[i] = r;
        exp_q[i].push_back(model(i, pos[i], r));
      end
    end
    repeat (2) @(posedge clk);
    chk("wrap_seen", 3, 16'(seen_wrap), 16'd1);
    for (int i = 0; i < NI; i++) begin
      chk("tgt_reset_done", i, 16'(tgt_done[i]), 16'd1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
